// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: binary-to-BCD shift-add-3 engine feeding a
// display register that is time-shared over NUM_DIGITS active-low anodes.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  overflow,
  output logic [3:0]            digit_bcd,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW    = $clog2(BIN_W + 1);

  localparam logic [63:0]       MAX_VAL   = 64'(10 ** NUM_DIGITS - 1);
  localparam logic [CW-1:0]     CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0]     LAST_STEP = SW'(BIN_W);
  localparam logic [BCD_W-1:0]  ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [SW-1:0]      step_q;
  logic               sat_q;
  logic [BCD_W-1:0]   disp_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      idx_nxt;
  logic [NUM_DIGITS-1:0] hi_zero;
  logic               blank_nxt;
  logic               start;

  // One shift-add-3 iteration: correct every nibble >= 5, then shift the whole chain.
  function automatic logic [BCD_W+BIN_W-1:0] dabble(input logic [BCD_W-1:0] bcd,
                                                    input logic [BIN_W-1:0] sh);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj, sh} << 1;
  endfunction

  assign start = (state_q == IDLE) && load;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load) state_d = CONV;
      CONV: if (step_q == LAST_STEP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CONV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      sat_q    <= 1'b0;
      disp_q   <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      shift_q <= bin_in;
      bcd_q   <= '0;
      step_q  <= '0;
      sat_q   <= (64'(bin_in) > MAX_VAL);
    end else if (state_q == CONV) begin
      if (step_q != LAST_STEP) begin
        {bcd_q, shift_q} <= dabble(bcd_q, shift_q);
        step_q           <= step_q + 1'b1;
      end else begin
        // Commit the finished value in a single edge so the scan never sees a partial result.
        disp_q   <= sat_q ? ALL_NINES : bcd_q;
        overflow <= sat_q;
      end
    end
  end

  always_comb begin
    idx_nxt = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
  end

  // hi_zero[i] is set when nibble i and all more significant nibbles are zero.
  always_comb begin
    logic run;
    hi_zero = '0;
    run     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run        = run && (disp_q[4*i +: 4] == 4'd0);
      hi_zero[i] = run;
    end
  end

  always_comb begin
    blank_nxt = blank_lz && (idx_nxt != '0) && hi_zero[idx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      digit_bcd <= 4'd0;
      anode     <= ~NUM_DIGITS'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_q     <= '0;
      idx_q     <= idx_nxt;
      digit_bcd <= disp_q[4*idx_nxt +: 4];
      anode     <= blank_nxt ? '1 : ~(NUM_DIGITS'(1) << idx_nxt);
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues expected conversions and scan
// steps; two monitors compare them when busy falls and at each scan step.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] bin_in = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic          busy;
  logic          overflow;
  logic [3:0]    digit_bcd;
  logic [ND-1:0] anode;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_in    (bin_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .busy      (busy),
    .overflow  (overflow),
    .digit_bcd (digit_bcd),
    .anode     (anode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] an;
    logic [3:0] bcd;
  } scan_t;

  typedef struct {
    int   len;
    logic ovf;
  } conv_t;

  scan_t scan_q[$];
  conv_t conv_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bench-side cycle count since reset release; the scan steps on every RD-th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scan monitor: at each scan step, compare the head entry once its digit comes round.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (cyc % RD == 0) && scan_q.size() > 0) begin
        int    cur;
        scan_t e;
        cur = (cyc / RD) % ND;
        if (scan_q[0].idx == cur) begin
          e = scan_q.pop_front();
          check($sformatf("anode_d%0d", cur), 32'(anode), 32'(e.an));
          check($sformatf("digit_bcd_d%0d", cur), 32'(digit_bcd), 32'(e.bcd));
        end
      end
    end
  end

  // Conversion monitor: measures each busy pulse and checks it when busy falls.
  initial begin
    int    blen;
    conv_t e;
    blen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        blen = 0;
      end else if (busy) begin
        blen++;
      end else if (blen > 0) begin
        if (conv_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_conversion: busy pulse of %0d cycles, expected none", blen);
        end else begin
          e = conv_q.pop_front();
          check("busy_len", 32'(blen), 32'(e.len));
          check("overflow", 32'(overflow), 32'(e.ovf));
        end
        blen = 0;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", t);
    end
  endtask

  task automatic load_val(input int v, input logic ovf);
    wait_idle();
    bin_in = BW'(v);
    load   = 1'b1;
    conv_q.push_back('{len: 15, ovf: ovf});
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done();
    wait_idle();
    @(negedge clk);
  endtask

  // Expected anodes/nibbles packed with digit 0 in the most significant nibble.
  task automatic push_scan(input logic [15:0] ans, input logic [15:0] bcds);
    for (int i = 0; i < ND; i++) begin
      scan_q.push_back('{idx: i, an: ans[15-4*i -: 4], bcd: bcds[15-4*i -: 4]});
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (scan_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (scan_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_drain: %0d scan entries unchecked, expected 0", scan_q.size());
      scan_q.delete();
    end
  endtask

  localparam logic [15:0] AN_ALL = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and free-running scan 0,1,2,3,0.
    repeat (3) @(posedge clk);
    push_scan(AN_ALL, 16'h0000);
    scan_q.push_back('{idx: 0, an: 4'b1110, bcd: 4'd0});
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    wait_drain();

    // 1234 decodes to 4,3,2,1 with a 15-cycle busy pulse.
    load_val(1234, 1'b0);
    wait_done();
    push_scan(AN_ALL, 16'h4321);
    wait_drain();

    // Saturation, then a normal value clears overflow.
    load_val(10000, 1'b1);
    wait_done();
    push_scan(AN_ALL, 16'h9999);
    wait_drain();
    load_val(42, 1'b0);
    wait_done();
    push_scan(AN_ALL, 16'h2400);
    wait_drain();

    // Leading-zero blanking, then blanking released.
    blank_lz = 1'b1;
    load_val(7, 1'b0);
    wait_done();
    push_scan({4'b1110, 4'b1111, 4'b1111, 4'b1111}, 16'h7000);
    wait_drain();
    blank_lz = 1'b0;
    push_scan(AN_ALL, 16'h7000);
    wait_drain();

    // Loads while busy (including the falling edge) are dropped.
    wait_idle();
    bin_in = BW'(500);
    load   = 1'b1;
    conv_q.push_back('{len: 15, ovf: 1'b0});
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy) begin
        bin_in = BW'(99);
        load   = 1'b1;
      end else begin
        load = 1'b0;
        break;
      end
    end
    load = 1'b0;
    @(negedge clk);
    push_scan(AN_ALL, 16'h0050);
    wait_drain();

    // A load on the edge right after busy falls is accepted.
    load_val(777, 1'b0);
    wait_idle();
    bin_in = BW'(99);
    load   = 1'b1;
    conv_q.push_back('{len: 15, ovf: 1'b0});
    @(negedge clk);
    load = 1'b0;
    wait_done();
    push_scan(AN_ALL, 16'h9900);
    wait_drain();

    // Reset in the middle of converting 8888 aborts it.
    wait_idle();
    bin_in = BW'(8888);
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_anode", 32'(anode), 32'b1110);
    check("abort_digit_bcd", 32'(digit_bcd), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    push_scan(AN_ALL, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    wait_drain();
    load_val(8888, 1'b0);
    wait_done();
    push_scan(AN_ALL, 16'h8888);
    wait_drain();

    repeat (20) @(negedge clk);
    check("conv_queue_empty", 32'(conv_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
